// File: rtl/mode_sequencer_if.sv
// Register-side bus of the mode sequencer: direct-load request in, mode state out.
// The sequencer takes the slave side and the register block takes the master side.
interface mode_sequencer_if #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = $clog2(NUM_MODES)
);
  logic                 load_en;
  logic [MODE_W-1:0]    load_mode;
  logic [MODE_W-1:0]    mode;
  logic [NUM_MODES-1:0] mode_onehot;
  logic                 mode_changed;
  logic                 load_err;

  modport master (
    output load_en, load_mode,
    input  mode, mode_onehot, mode_changed, load_err
  );

  modport slave (
    input  load_en, load_mode,
    output mode, mode_onehot, mode_changed, load_err
  );
endinterface

// File: rtl/mode_sequencer.sv
// N-way synth mode register with debounced next/prev buttons and a direct-load path.
// Key events and loads are merged with load > cancel > step priority.
module mode_sequencer #(
  parameter int NUM_MODES       = 4,
  parameter int MODE_W          = $clog2(NUM_MODES),
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WRAP            = 1,
  parameter int RESET_MODE      = 0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_next,
  input  logic             key_prev,
  mode_sequencer_if.slave  bus
);

  generate
    if (NUM_MODES < 2 || NUM_MODES > 256) begin : g_bad_num_modes
      $error("mode_sequencer: NUM_MODES must be in 2..256");
    end
    if (RESET_MODE < 0 || RESET_MODE >= NUM_MODES) begin : g_bad_reset_mode
      $error("mode_sequencer: RESET_MODE must be below NUM_MODES");
    end
    if (MODE_W != $clog2(NUM_MODES)) begin : g_bad_mode_w
      $error("mode_sequencer: MODE_W is derived and must not be overridden");
    end
    if (DEBOUNCE_CYCLES < 0) begin : g_bad_debounce
      $error("mode_sequencer: DEBOUNCE_CYCLES must not be negative");
    end
  endgenerate

  localparam int unsigned          NUM_MODES_U  = NUM_MODES;
  localparam logic [MODE_W-1:0]    MODE_MAX     = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0]    RESET_VAL    = MODE_W'(RESET_MODE);
  localparam logic [NUM_MODES-1:0] ONEHOT_ONE   = NUM_MODES'(1);
  localparam logic [NUM_MODES-1:0] RESET_ONEHOT = ONEHOT_ONE << RESET_MODE;

  // Bit 0 carries the next key, bit 1 the prev key.
  logic [1:0] key_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] deb_lvl;
  logic [1:0] deb_q;
  logic [1:0] key_evt;

  assign key_raw = {key_prev, key_next};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      deb_q <= deb_lvl;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb_lvl = sync2;
    end else begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      for (genvar k = 0; k < 2; k++) begin : g_key
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        // The level flips on the cycle that would complete the stable run.
        always_ff @(posedge clk or negedge n_rst) begin
          if (!n_rst) begin
            cnt <= '0;
            lvl <= 1'b0;
          end else if (sync2[k] == lvl) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            lvl <= sync2[k];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        assign deb_lvl[k] = lvl;
      end
    end
  endgenerate

  assign key_evt = deb_lvl & ~deb_q;

  logic [MODE_W-1:0]    mode_q;
  logic [MODE_W-1:0]    mode_nxt;
  logic [NUM_MODES-1:0] onehot_q;
  logic                 changed_q;
  logic                 err_q;
  logic                 err_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q    <= RESET_VAL;
      onehot_q  <= RESET_ONEHOT;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mode_q    <= mode_nxt;
      onehot_q  <= ONEHOT_ONE << mode_nxt;
      changed_q <= (mode_nxt != mode_q);
      err_q     <= err_nxt;
    end
  end

  // A load swallows any key event of the same cycle; opposing events cancel.
  always_comb begin
    mode_nxt = mode_q;
    err_nxt  = 1'b0;
    if (bus.load_en) begin
      if (32'(bus.load_mode) < NUM_MODES_U) begin
        mode_nxt = bus.load_mode;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (key_evt[0] && !key_evt[1]) begin
      if (mode_q != MODE_MAX) begin
        mode_nxt = mode_q + 1'b1;
      end else if (WRAP != 0) begin
        mode_nxt = '0;
      end
    end else if (key_evt[1] && !key_evt[0]) begin
      if (mode_q != '0) begin
        mode_nxt = mode_q - 1'b1;
      end else if (WRAP != 0) begin
        mode_nxt = MODE_MAX;
      end
    end
  end

  always_comb begin
    bus.mode         = mode_q;
    bus.mode_onehot  = onehot_q;
    bus.mode_changed = changed_q;
    bus.load_err     = err_q;
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: default, saturating and 5-mode/no-debounce
// instances share clock and reset; each has its own keys and register bus.
module tb_mode_sequencer;

  logic       clk;
  logic       n_rst;
  logic [5:0] keys;

  localparam logic [5:0] K_NEXT_DEF  = 6'b000001;
  localparam logic [5:0] K_PREV_DEF  = 6'b000010;
  localparam logic [5:0] K_NEXT_SAT  = 6'b000100;
  localparam logic [5:0] K_PREV_SAT  = 6'b001000;
  localparam logic [5:0] K_NEXT_FIVE = 6'b010000;
  localparam logic [5:0] K_PREV_FIVE = 6'b100000;

  int n_cmp;
  int n_err;
  int chg_def;
  int chg_sat;
  int chg_five;
  int snap_def;
  int snap_sat;

  mode_sequencer_if #(.NUM_MODES(4)) bus_def ();
  mode_sequencer_if #(.NUM_MODES(4)) bus_sat ();
  mode_sequencer_if #(.NUM_MODES(5)) bus_five ();

  mode_sequencer #(.NUM_MODES(4), .DEBOUNCE_CYCLES(4), .WRAP(1), .RESET_MODE(0)) u_def (
    .clk(clk), .n_rst(n_rst), .key_next(keys[0]), .key_prev(keys[1]), .bus(bus_def)
  );

  mode_sequencer #(.NUM_MODES(4), .DEBOUNCE_CYCLES(4), .WRAP(0), .RESET_MODE(0)) u_sat (
    .clk(clk), .n_rst(n_rst), .key_next(keys[2]), .key_prev(keys[3]), .bus(bus_sat)
  );

  mode_sequencer #(.NUM_MODES(5), .DEBOUNCE_CYCLES(0), .WRAP(1), .RESET_MODE(0)) u_five (
    .clk(clk), .n_rst(n_rst), .key_next(keys[4]), .key_prev(keys[5]), .bus(bus_five)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters let a step check how many change strobes it produced.
  always @(negedge clk) begin
    if (bus_def.mode_changed === 1'b1) chg_def++;
    if (bus_sat.mode_changed === 1'b1) chg_sat++;
    if (bus_five.mode_changed === 1'b1) chg_five++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [5:0] mask, input int hold);
    keys = keys | mask;
    tick(hold);
    keys = keys & ~mask;
    tick(10);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    chg_def = 0; chg_sat = 0; chg_five = 0;
    n_rst = 1'b0;
    keys = '0;
    bus_def.load_en = 1'b0;  bus_def.load_mode = '0;
    bus_sat.load_en = 1'b0;  bus_sat.load_mode = '0;
    bus_five.load_en = 1'b0; bus_five.load_mode = '0;

    $display("[TB] reset values");
    tick(3);
    check_output("rst_mode",     bus_def.mode, 0);
    check_output("rst_onehot",   bus_def.mode_onehot, 4'b0001);
    check_output("rst_changed",  bus_def.mode_changed, 0);
    check_output("rst_err",      bus_def.load_err, 0);
    check_output("rst_five_oh",  bus_five.mode_onehot, 5'b00001);
    n_rst = 1'b1;
    tick(2);

    $display("[TB] held next key, latency and no auto-repeat");
    keys[0] = 1'b1;
    tick(6);
    check_output("lat_edge6_mode", bus_def.mode, 0);
    tick(1);
    check_output("lat_edge7_mode",    bus_def.mode, 1);
    check_output("lat_edge7_changed", bus_def.mode_changed, 1);
    check_output("lat_edge7_onehot",  bus_def.mode_onehot, 4'b0010);
    tick(1);
    check_output("lat_pulse_len", bus_def.mode_changed, 0);
    tick(12);
    check_output("held_no_repeat", bus_def.mode, 1);
    keys[0] = 1'b0;
    tick(10);
    check_output("release_silent", bus_def.mode, 1);
    check_output("held_pulses", 32'(chg_def), 1);

    $display("[TB] wrap and saturate");
    press(K_PREV_DEF | K_NEXT_SAT, 8);
    check_output("wrap_a_def", bus_def.mode, 0);
    check_output("sat_a_sat",  bus_sat.mode, 1);
    snap_def = chg_def;
    press(K_NEXT_DEF | K_NEXT_SAT, 8);
    check_output("wrap_b_def", bus_def.mode, 1);
    check_output("sat_b_sat",  bus_sat.mode, 2);
    press(K_NEXT_DEF | K_NEXT_SAT, 8);
    check_output("wrap_c_def", bus_def.mode, 2);
    check_output("sat_c_sat",  bus_sat.mode, 3);
    snap_sat = chg_sat;
    press(K_NEXT_DEF | K_NEXT_SAT, 8);
    check_output("wrap_d_def", bus_def.mode, 3);
    check_output("sat_top_hold",   bus_sat.mode, 3);
    check_output("sat_top_nopulse", 32'(chg_sat - snap_sat), 0);
    press(K_NEXT_DEF | K_PREV_SAT, 8);
    check_output("wrap_top_to_0", bus_def.mode, 0);
    check_output("wrap_four_pulses", 32'(chg_def - snap_def), 4);
    check_output("sat_e_sat", bus_sat.mode, 2);
    press(K_PREV_DEF | K_PREV_SAT, 8);
    check_output("wrap_0_to_top", bus_def.mode, 3);
    check_output("sat_f_sat", bus_sat.mode, 1);
    press(K_PREV_SAT, 8);
    check_output("sat_g_sat", bus_sat.mode, 0);
    snap_sat = chg_sat;
    press(K_PREV_SAT, 8);
    check_output("sat_bottom_hold",    bus_sat.mode, 0);
    check_output("sat_bottom_nopulse", 32'(chg_sat - snap_sat), 0);

    $display("[TB] bounce rejection");
    snap_def = chg_def;
    for (int i = 0; i < 3; i++) begin
      keys[0] = 1'b1;
      tick(2);
      keys[0] = 1'b0;
      tick(2);
    end
    tick(10);
    check_output("bounce_mode", bus_def.mode, 3);
    press(K_NEXT_DEF, 3);
    check_output("short_pulse_mode",   bus_def.mode, 3);
    check_output("bounce_no_pulses", 32'(chg_def - snap_def), 0);

    $display("[TB] simultaneous events");
    press(K_NEXT_DEF | K_PREV_DEF, 8);
    check_output("cancel_mode",   bus_def.mode, 3);
    check_output("cancel_pulses", 32'(chg_def - snap_def), 0);
    keys[0] = 1'b1;
    tick(6);
    bus_def.load_en = 1'b1;
    bus_def.load_mode = 2'd2;
    tick(1);
    bus_def.load_en = 1'b0;
    check_output("load_vs_key_mode",    bus_def.mode, 2);
    check_output("load_vs_key_changed", bus_def.mode_changed, 1);
    tick(1);
    check_output("key_dropped_mode", bus_def.mode, 2);
    keys[0] = 1'b0;
    tick(10);
    check_output("key_dropped_later", bus_def.mode, 2);

    $display("[TB] direct load");
    bus_def.load_en = 1'b1;
    bus_def.load_mode = 2'd1;
    tick(1);
    check_output("load1_mode", bus_def.mode, 1);
    bus_def.load_mode = 2'd3;
    tick(1);
    check_output("load3_mode",    bus_def.mode, 3);
    check_output("load3_changed", bus_def.mode_changed, 1);
    check_output("load3_onehot",  bus_def.mode_onehot, 4'b1000);
    check_output("load3_err",     bus_def.load_err, 0);
    tick(1);
    check_output("reload_mode",    bus_def.mode, 3);
    check_output("reload_changed", bus_def.mode_changed, 0);
    bus_def.load_en = 1'b0;

    bus_five.load_en = 1'b1;
    bus_five.load_mode = 3'd6;
    tick(1);
    check_output("bad_load_mode",    bus_five.mode, 0);
    check_output("bad_load_err",     bus_five.load_err, 1);
    check_output("bad_load_changed", bus_five.mode_changed, 0);
    bus_five.load_en = 1'b0;
    tick(1);
    check_output("bad_load_err_len", bus_five.load_err, 0);
    bus_five.load_en = 1'b1;
    bus_five.load_mode = 3'd5;
    tick(1);
    check_output("edge_load_err",  bus_five.load_err, 1);
    check_output("edge_load_mode", bus_five.mode, 0);
    bus_five.load_mode = 3'd4;
    tick(1);
    bus_five.load_en = 1'b0;
    check_output("five_load4_mode",   bus_five.mode, 4);
    check_output("five_load4_onehot", bus_five.mode_onehot, 5'b10000);
    check_output("five_load4_err",    bus_five.load_err, 0);
    keys[4] = 1'b1;
    tick(2);
    check_output("five_edge2_mode", bus_five.mode, 4);
    tick(1);
    check_output("five_wrap_mode",    bus_five.mode, 0);
    check_output("five_wrap_changed", bus_five.mode_changed, 1);
    check_output("five_wrap_onehot",  bus_five.mode_onehot, 5'b00001);
    keys[4] = 1'b0;
    tick(4);
    press(K_PREV_FIVE, 4);
    check_output("five_prev_wrap", bus_five.mode, 4);

    $display("[TB] reset mid-operation");
    keys[0] = 1'b1;
    tick(3);
    #2;
    n_rst = 1'b0;
    keys[0] = 1'b0;
    #1;
    check_output("async_rst_mode",   bus_def.mode, 0);
    check_output("async_rst_onehot", bus_def.mode_onehot, 4'b0001);
    check_output("async_rst_five",   bus_five.mode, 0);
    #1;
    n_rst = 1'b1;
    snap_def = chg_def;
    tick(12);
    check_output("post_rst_mode",      bus_def.mode, 0);
    check_output("post_rst_no_pulses", 32'(chg_def - snap_def), 0);

    keys[0] = 1'b1;
    n_rst = 1'b0;
    #3;
    n_rst = 1'b1;
    tick(6);
    check_output("held_thru_rst_edge6", bus_def.mode, 0);
    tick(1);
    check_output("held_thru_rst_mode",    bus_def.mode, 1);
    check_output("held_thru_rst_changed", bus_def.mode_changed, 1);
    keys[0] = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Parametrised successor to the single-key waveform mode FSM. It owns the N-way synth mode register (off/square/triangle/sawtooth/... up to NUM_MODES).
- Inputs: raw async next/prev buttons and a synchronous direct-load port from the register interface.
- Front end: each button is synchronised, debounced and edge-detected.
- Output: a binary and one-hot mode to the waveform generators, plus a change strobe.

Parameters:
NUM_MODES, 4, number of modes; legal values are 2 to 256.
MODE_W, $clog2(NUM_MODES), derived width of mode; not to be overridden.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a level change; 0 bypasses the debouncer.
WRAP, 1, 1 means wrap at the ends; 0 means saturate at the ends.
RESET_MODE, 0, mode value after reset; must be less than NUM_MODES.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
key_next  in  1  raw async button, active high: advance mode.
key_prev  in  1  raw async button, active high: step mode back.
load_en  in  1  synchronous single-cycle strobe: load load_mode.
load_mode  in  MODE_W  value to load when load_en=1.
mode  out  MODE_W  current mode, registered.
mode_onehot  out  NUM_MODES  one-hot decode of mode, registered, same cycle as mode.
mode_changed  out  1  1-cycle pulse, registered, high in the first cycle mode holds a new value.
load_err  out  1  1-cycle pulse, registered: load attempted with load_mode >= NUM_MODES.

Behaviour:
- Reset (async assert, sync-clean deassert inside the flops):
  - mode=RESET_MODE; mode_onehot = 1<<RESET_MODE.
  - mode_changed=0, load_err=0.
  - All sync flops, debounced levels and debounce counters = 0.
  - Reset mid-debounce discards the partial count.
- Per-key front end (next and prev are identical and independent):
  - 2-flop synchroniser.
  - Debounce counter: increments while sync != debounced; clears when sync == debounced. A glitch shorter than DEBOUNCE_CYCLES produces no event.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sync value.
  - Press event = debounced 0->1; exactly one event per press.
  - Release (debounced 1->0) is silent.
  - Holding a key produces no auto-repeat.
- Latency, key high held steady: mode and mode_changed update at the (DEBOUNCE_CYCLES+3)th rising edge of clk, counting the first edge that samples the key high as edge 1. With the default DEBOUNCE_CYCLES=4 this is edge 7. With DEBOUNCE_CYCLES=0 it is edge 3.
- A key held high through reset release counts as one press once debounced, because debounced resets to 0.
- Update priority, evaluated each cycle:
  1. load_en=1:
     - load_mode < NUM_MODES: mode <= load_mode.
     - load_mode >= NUM_MODES: mode holds and load_err pulses.
     - Any key events in the same cycle are dropped, not queued.
  2. next and prev events in the same cycle: they cancel; no change, no pulse.
  3. next event only: mode+1.
     - At NUM_MODES-1: goes to 0 if WRAP=1; holds if WRAP=0.
  4. prev event only: mode-1.
     - At 0: goes to NUM_MODES-1 if WRAP=1; holds if WRAP=0.
- mode_changed pulses only when the registered mode value actually differs from its previous value. No pulse for:
  - a load of the current value;
  - a saturated step;
  - cancelled events.
- mode never takes a value >= NUM_MODES. mode_onehot always has exactly one bit set.
- Non-power-of-2 NUM_MODES (e.g. 5): wrap is at NUM_MODES-1, not at 2^MODE_W-1.
- Elaboration-time checks: NUM_MODES >= 2; RESET_MODE < NUM_MODES.

Test Plan:
1. Defaults. Reset, then key_next high for 20 cycles -> mode 0->1 at edge 7 after the first sample. mode_changed high for 1 cycle. mode_onehot=4'b0010. No further change while held.
2. Wrap. Four separate key_next presses from mode 0 -> sequence 1,2,3,0 with four mode_changed pulses. key_prev at mode 0 -> mode 3. Repeat with WRAP=0: next at 3 holds 3 with no pulse; prev at 0 holds 0.
3. Bounce. key_next toggles high/low every 2 cycles for 12 cycles, then low -> no change and no pulse. A 3-cycle high pulse with DEBOUNCE_CYCLES=4 is also rejected.
4. Simultaneous events. key_next and key_prev rise on the same edge -> events coincide and cancel: mode unchanged, mode_changed=0. In the same run, a load_en with load_mode=2 coincident with a next event -> mode=2 and the key event is dropped.
5. Direct load. load_en with load_mode=3 from mode 1 -> mode=3 next edge with pulse. Loading 3 again -> no pulse. With NUM_MODES=5: load_mode=6 -> mode holds and load_err pulses for 1 cycle; next from 4 -> 0.
6. Reset mid-operation. Assert n_rst low asynchronously during a debounce count and mid-cycle -> outputs go to reset values immediately, not at the next clk edge. After release, with keys low -> mode=RESET_MODE and no spurious pulse.
